pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/pll_lock_sequencer_if.sv | 42 ++++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding,
// default timing constants and synchronizer depth.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RESET_HOLD_CYCLES  = 16;
    localparam int DEF_CNT_W              = 16;
    localparam int DEF_LOSS_CNT_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES     = 65535;

    localparam int SYNC_STAGES = 2;

    // States in which the PLL is still being qualified (watchdog territory).
    function automatic logic is_qualifying(seq_state_e s);
        return (s == ST_WAIT_LOCK) || (s == ST_STABLE);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL/software side and the lock sequencer.
// lock_timeout exists only when PLL_SEQ_TIMEOUT_EN is defined.
interface pll_lock_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  pll_locked;
    logic                  restart_req;
    logic                  core_reset;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] lock_lost_count;
    logic [1:0]            state_dbg;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic                  lock_timeout;
`endif

    // Environment side: PLL flag and software restart in, status out.
    modport master (
        output pll_locked,
        output restart_req,
        input  core_reset,
        input  ready,
        input  lock_lost_count,
`ifdef PLL_SEQ_TIMEOUT_EN
        input  lock_timeout,
`endif
        input  state_dbg
    );

    // Sequencer side.
    modport slave (
        input  pll_locked,
        input  restart_req,
        output core_reset,
        output ready,
        output lock_lost_count,
`ifdef PLL_SEQ_TIMEOUT_EN
        output lock_timeout,
`endif
        output state_dbg
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit synchronizer, SYNC_STAGES flops deep, synchronous
// active-high reset to 0.
module sync_2ff
    import pll_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the core in reset until the PLL lock has been stable for a
// programmable time, re-applies reset on lock loss or software restart,
// and counts lock losses seen while running.
// Optional watchdog (lock_timeout) enabled by defining PLL_SEQ_TIMEOUT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------
// WAIT_LOCK  | core in reset, waiting for synchronized lock
// STABLE     | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// HOLD       | lock qualified, core reset held RESET_HOLD_CYCLES more
// RUN        | core released, ready asserted
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int CNT_W              = DEF_CNT_W,
    parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
)(
    input  logic               clk,
    input  logic               reset,
    pll_lock_sequencer_if.slave bus
);

    // The shared phase counter must be able to reach every terminal count.
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES >= (2 ** CNT_W)) begin : g_chk_stable
        $error("LOCK_STABLE_CYCLES out of range for CNT_W");
    end
    if (RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES >= (2 ** CNT_W)) begin : g_chk_hold
        $error("RESET_HOLD_CYCLES out of range for CNT_W");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic                  locked_s;
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  core_reset_q;
    logic                  ready_q;

    sync_2ff u_sync_locked (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.pll_locked),
        .q_o   (locked_s)
    );

    // Next-state, phase counter and loss counter decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_TC) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_TC) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Lock loss wins over a coincident restart request.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (loss_q != '1) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end else if (bus.restart_req) begin
                    // Lock is still good, so skip re-qualification.
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow state_d so they
    // change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= '0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            core_reset_q <= (state_d != ST_RUN);
            ready_q      <= (state_d == ST_RUN);
        end
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             timeout_q;

    // Watchdog counts time spent qualifying; it saturates at the limit and
    // clears once the sequencer reaches HOLD.
    always_comb begin
        wdog_d = '0;
        if (is_qualifying(state_q) && (state_d != ST_HOLD)) begin
            wdog_d = (wdog_q == TIMEOUT_TC) ? wdog_q : wdog_q + CNT_W'(1);
        end
    end

    // Sticky timeout flag; sequencing is unaffected by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q | (wdog_d == TIMEOUT_TC);
        end
    end

    assign bus.lock_timeout = timeout_q;
`endif

    assign bus.core_reset      = core_reset_q;
    assign bus.ready           = ready_q;
    assign bus.lock_lost_count = loss_q;
    assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with LOCK_STABLE_CYCLES=8,
// RESET_HOLD_CYCLES=4 (and TIMEOUT_CYCLES=20 when PLL_SEQ_TIMEOUT_EN).
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pll_lock_sequencer_if #(.LOSS_CNT_W(8)) bus ();

    pll_lock_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .CNT_W              (16),
        .LOSS_CNT_W         (8),
        .TIMEOUT_CYCLES     (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       rq;
        logic [1:0] st;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ready rises, bounded; returns the number of edges taken.
    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({name, "_ready_reached"}, bus.ready, 1);
    endtask

    function automatic logic [1:0] pwr_state(int e);
        if (e < 3) return 2'd0;
        if (e < 11) return 2'd1;
        if (e < 15) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [1:0] glitch_state(int e);
        if (e < 3) return 2'd0;
        if (e <= 7) return 2'd1;
        if (e == 8) return 2'd0;
        if (e <= 16) return 2'd1;
        if (e <= 20) return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        int n;
        logic [31:0] exp_cnt;

        // Reset, power-up with lock from edge 1, then mid-run reset and a
        // glitchy lock (low for one cycle after 5 high).
        for (int i = 0; i < 2; i++) vt.push_back('{1'b1, 1'b0, 1'b0, 2'd0});
        for (int e = 1; e <= 16; e++) vt.push_back('{1'b0, 1'b1, 1'b0, pwr_state(e)});
        vt.push_back('{1'b1, 1'b1, 1'b0, 2'd0});
        for (int e = 1; e <= 22; e++) vt.push_back('{1'b0, (e == 6) ? 1'b0 : 1'b1, 1'b0, glitch_state(e)});

        reset           = 1'b1;
        bus.pll_locked  = 1'b0;
        bus.restart_req = 1'b0;

        foreach (vt[i]) begin
            reset           = vt[i].rst;
            bus.pll_locked  = vt[i].lk;
            bus.restart_req = vt[i].rq;
            step();
            chk($sformatf("vec%0d_state", i), bus.state_dbg, vt[i].st);
            chk($sformatf("vec%0d_core_reset", i), bus.core_reset, (vt[i].st != 2'd3));
            chk($sformatf("vec%0d_ready", i), bus.ready, (vt[i].st == 2'd3));
            chk($sformatf("vec%0d_loss_cnt", i), bus.lock_lost_count, 0);
        end

        // Lock loss in RUN: input low for 3 cycles.
        bus.pll_locked = 1'b0;
        step();
        chk("loss_e1_core_reset", bus.core_reset, 0);
        step();
        chk("loss_e2_state", bus.state_dbg, 3);
        step();
        chk("loss_e3_state", bus.state_dbg, 0);
        chk("loss_e3_core_reset", bus.core_reset, 1);
        chk("loss_e3_ready", bus.ready, 0);
        chk("loss_e3_count", bus.lock_lost_count, 1);
        bus.pll_locked = 1'b1;
        wait_ready("loss_requal", n);
        chk("loss_requal_edges", n, 15);
        chk("loss_count_after", bus.lock_lost_count, 1);

        // Restart request in RUN: 4 cycles of core reset.
        bus.restart_req = 1'b1;
        step();
        bus.restart_req = 1'b0;
        chk("restart_state", bus.state_dbg, 2);
        chk("restart_core_reset", bus.core_reset, 1);
        chk("restart_ready", bus.ready, 0);
        wait_ready("restart", n);
        chk("restart_hold_edges", n, 4);
        chk("restart_count", bus.lock_lost_count, 1);

        // Restart coincident with lock loss: loss wins.
        bus.pll_locked = 1'b0;
        step();
        step();
        bus.restart_req = 1'b1;
        step();
        bus.restart_req = 1'b0;
        chk("prio_state", bus.state_dbg, 0);
        chk("prio_count", bus.lock_lost_count, 2);
        // Restart outside RUN is ignored.
        bus.restart_req = 1'b1;
        step();
        bus.restart_req = 1'b0;
        chk("restart_in_wait_state", bus.state_dbg, 0);
        bus.pll_locked = 1'b1;
        wait_ready("prio", n);

        // Saturation of the lock-loss counter.
        exp_cnt = 2;
        for (int i = 0; i < 260; i++) begin
            bus.pll_locked = 1'b0;
            step();
            bus.pll_locked = 1'b1;
            step();
            step();
            if (exp_cnt < 255) exp_cnt++;
            chk($sformatf("sat%0d_state", i), bus.state_dbg, 0);
            chk($sformatf("sat%0d_count", i), bus.lock_lost_count, exp_cnt);
            wait_ready($sformatf("sat%0d", i), n);
        end
        chk("sat_final_count", bus.lock_lost_count, 255);

`ifdef PLL_SEQ_TIMEOUT_EN
        // Watchdog: lock held low from reset.
        reset          = 1'b1;
        bus.pll_locked = 1'b0;
        step();
        chk("to_reset_flag", bus.lock_timeout, 0);
        reset = 1'b0;
        for (int e = 1; e <= 19; e++) step();
        chk("to_edge19_flag", bus.lock_timeout, 0);
        step();
        chk("to_edge20_flag", bus.lock_timeout, 1);
        bus.pll_locked = 1'b1;
        wait_ready("to_after_lock", n);
        chk("to_sticky_flag", bus.lock_timeout, 1);
`endif

        // Mid-run reset returns every output to its reset value.
        reset = 1'b1;
        step();
        chk("rst_state", bus.state_dbg, 0);
        chk("rst_core_reset", bus.core_reset, 1);
        chk("rst_ready", bus.ready, 0);
        chk("rst_count", bus.lock_lost_count, 0);
`ifdef PLL_SEQ_TIMEOUT_EN
        chk("rst_timeout", bus.lock_timeout, 0);
`endif
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
